seg7_scan_counter: RTL and testbench



---
 rtl/seg7_pkg.sv | 35 +++
 rtl/bcd_counter.sv | 92 +++++++++
 rtl/seg7_scan_counter.sv | 117 +++++++++++
 tb/tb_seg7_scan_counter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Segment encodings and BCD-to-segment decode shared by the 7-segment scan counter.
// Bit order is leds[0:6]; pattern strings read left to right from leds[0].
package seg7_pkg;

    localparam logic [0:6] SEG_0     = 7'b0111111;
    localparam logic [0:6] SEG_1     = 7'b0001001;
    localparam logic [0:6] SEG_2     = 7'b1011110;
    localparam logic [0:6] SEG_3     = 7'b1011011;
    localparam logic [0:6] SEG_4     = 7'b1101001;
    localparam logic [0:6] SEG_5     = 7'b1110011;
    localparam logic [0:6] SEG_6     = 7'b1110111;
    localparam logic [0:6] SEG_7     = 7'b0011001;
    localparam logic [0:6] SEG_8     = 7'b1111111;
    localparam logic [0:6] SEG_9     = 7'b1111011;
    localparam logic [0:6] SEG_BLANK = 7'b0000000;

    function automatic logic [0:6] bcd_to_seg(input logic [3:0] d);
        logic [0:6] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// N-digit BCD up/down counter with parallel load; a load always takes priority over a step.
// Loads containing a non-BCD digit are rejected and flagged for one cycle.
module bcd_counter
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_i,
    input  logic                    dir_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_val_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    wrap_o,
    output logic                    load_err_o,
    output logic                    load_ok_o
);

    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic                    err_q, err_d;
    logic [4*NUM_DIGITS-1:0] stepped;
    logic                    carry;
    logic                    digits_ok;
    logic [3:0]              dig;

    // Ripple carry/borrow; a carry out of the top digit means the count wrapped.
    always_comb begin
        stepped   = count_q;
        carry     = 1'b1;
        digits_ok = 1'b1;
        dig       = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (!dir_i) begin
                    if (dig == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = dig + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = dig - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
            if (load_val_i[4*i +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load_i) begin
            if (digits_ok) begin
                count_d = load_val_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (step_i) begin
            count_d = stepped;
            wrap_d  = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count_o    = count_q;
    assign wrap_o     = wrap_q;
    assign load_err_o = err_q;
    assign load_ok_o  = load_i && digits_ok;

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD counter on a programmable tick, time-multiplexed onto one 7-segment bus
// with one-hot digit enables and optional leading-zero blanking.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 13500000,
    parameter int unsigned SCAN_DIV   = 13500,
    parameter bit          LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    down,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic                    load_ready,
    output logic                    load_err,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [0:6]              leds,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TW-1:0]           tick_q;
    logic [SW-1:0]           scan_q;
    logic [IW-1:0]           idx_q;
    logic [0:6]              leds_q, leds_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    step;
    logic                    load_ok;
    logic [4*NUM_DIGITS-1:0] count;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;

    assign step = run && (tick_q == TW'(TICK_DIV - 1));

    bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (step),
        .dir_i      (down),
        .load_i     (load_valid),
        .load_val_i (load_bcd),
        .count_o    (count),
        .wrap_o     (wrap),
        .load_err_o (load_err),
        .load_ok_o  (load_ok)
    );

    // A rejected load freezes the tick for that cycle, an accepted one restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (load_valid) begin
            if (load_ok) begin
                tick_q <= '0;
            end
        end else if (run) begin
            tick_q <= step ? '0 : tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_q <= '0;
            idx_q  <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            scan_q <= scan_q + SW'(1);
        end
    end

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_above = zero_above && (count[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[NUM_DIGITS-1-k] = LZ_BLANK && zero_above && (k != NUM_DIGITS - 1);
        end
    end

    always_comb begin
        dig_d  = '0;
        leds_d = SEG_BLANK;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dig_d[i] = 1'b1;
                leds_d   = blank[i] ? SEG_BLANK : bcd_to_seg(count[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds_q <= SEG_BLANK;
            dig_q  <= '0;
        end else begin
            leds_q <= leds_d;
            dig_q  <= dig_d;
        end
    end

    assign load_ready = 1'b1;
    assign count_bcd  = count;
    assign leds       = leds_q;
    assign dig_en     = dig_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Directed self-checking bench for seg7_scan_counter (4 digits, tick every 4, scan every 2).
module tb_seg7_scan_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        down;
    logic        load_valid;
    logic [15:0] load_bcd;
    logic        load_ready;
    logic        load_err;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [0:6]  leds;
    logic [3:0]  dig_en;

    int tests = 0;
    int fails = 0;

    localparam logic [0:6] S0 = 7'b0111111;
    localparam logic [0:6] S1 = 7'b0001001;
    localparam logic [0:6] S9 = 7'b1111011;
    localparam logic [0:6] SB = 7'b0000000;

    logic [0:6] cap_seg [4];
    int         cap_hit [4];
    int         cap_bad;

    always #5 clk = ~clk;

    seg7_scan_counter #(
        .NUM_DIGITS (4),
        .TICK_DIV   (4),
        .SCAN_DIV   (2),
        .LZ_BLANK   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .down       (down),
        .load_valid (load_valid),
        .load_bcd   (load_bcd),
        .load_ready (load_ready),
        .load_err   (load_err),
        .count_bcd  (count_bcd),
        .wrap       (wrap),
        .leds       (leds),
        .dig_en     (dig_en)
    );

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Records the pattern shown in each digit slot over one settle cycle plus 8 samples.
    task automatic capture_scan();
        cap_bad = 0;
        for (int i = 0; i < 4; i++) begin
            cap_hit[i] = 0;
            cap_seg[i] = 7'bxxxxxxx;
        end
        tick1();
        repeat (8) begin
            tick1();
            case (dig_en)
                4'b0001: begin cap_seg[0] = leds; cap_hit[0]++; end
                4'b0010: begin cap_seg[1] = leds; cap_hit[1]++; end
                4'b0100: begin cap_seg[2] = leds; cap_hit[2]++; end
                4'b1000: begin cap_seg[3] = leds; cap_hit[3]++; end
                default: cap_bad++;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; down = 1'b0; load_valid = 1'b0; load_bcd = '0;
        tick1(); tick1();
        tests++;
        if (count_bcd !== 16'h0000 || wrap !== 1'b0 || load_err !== 1'b0 || load_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctrl: count=%h wrap=%b err=%b ready=%b, want 0000 0 0 1",
                     count_bcd, wrap, load_err, load_ready);
        end
        tests++;
        if (leds !== SB || dig_en !== 4'b0000) begin
            fails++;
            $display("FAIL reset_disp: leds=%b dig_en=%b, want 0000000 0000", leds, dig_en);
        end
    endtask

    task automatic test_count_up();
        logic [0:6] exp [4];
        exp = '{S0, S1, SB, SB};
        rst_n = 1'b1; run = 1'b1;
        repeat (40) tick1();
        run = 1'b0;
        tests++;
        if (count_bcd !== 16'h0010) begin
            fails++;
            $display("FAIL up_40: count=%h, want 0010", count_bcd);
        end
        capture_scan();
        tests++;
        if (cap_bad != 0) begin
            fails++;
            $display("FAIL up_scan_onehot: bad=%0d, want 0", cap_bad);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cap_hit[i] == 0 || cap_seg[i] !== exp[i]) begin
                fails++;
                $display("FAIL up_digit%0d: leds=%b hits=%0d, want %b", i, cap_seg[i], cap_hit[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap_up();
        logic [0:6] exp [4];
        exp = '{S0, SB, SB, SB};
        load_bcd = 16'h9998; load_valid = 1'b1;
        tick1();
        load_valid = 1'b0;
        tests++;
        if (count_bcd !== 16'h9998 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL load_9998: count=%h err=%b, want 9998 0", count_bcd, load_err);
        end
        run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick1();
            if (i == 4) begin
                tests++;
                if (count_bcd !== 16'h9999 || wrap !== 1'b0) begin
                    fails++;
                    $display("FAIL step_9999: count=%h wrap=%b, want 9999 0", count_bcd, wrap);
                end
            end
            if (i == 7) begin
                tests++;
                if (wrap !== 1'b0) begin
                    fails++;
                    $display("FAIL wrap_early: wrap=%b, want 0", wrap);
                end
            end
            if (i == 8) begin
                tests++;
                if (count_bcd !== 16'h0000 || wrap !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_up: count=%h wrap=%b, want 0000 1", count_bcd, wrap);
                end
            end
        end
        run = 1'b0;
        tick1();
        tests++;
        if (wrap !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pulse_up: wrap=%b, want 0", wrap);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cap_hit[i] == 0 || cap_seg[i] !== exp[i]) begin
                fails++;
                $display("FAIL blank_digit%0d: leds=%b hits=%0d, want %b", i, cap_seg[i], cap_hit[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap_down();
        down = 1'b1; run = 1'b1;
        repeat (4) tick1();
        tests++;
        if (count_bcd !== 16'h9999 || wrap !== 1'b1) begin
            fails++;
            $display("FAIL wrap_down: count=%h wrap=%b, want 9999 1", count_bcd, wrap);
        end
        run = 1'b0; down = 1'b0;
        tick1();
        tests++;
        if (wrap !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pulse_down: wrap=%b, want 0", wrap);
        end
        capture_scan();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (cap_hit[i] == 0 || cap_seg[i] !== S9) begin
                fails++;
                $display("FAIL nine_digit%0d: leds=%b hits=%0d, want %b", i, cap_seg[i], cap_hit[i], S9);
            end
        end
    endtask

    task automatic test_load_priority();
        load_bcd = 16'h12A4; load_valid = 1'b1;
        tick1();
        load_valid = 1'b0;
        tests++;
        if (load_err !== 1'b1 || count_bcd !== 16'h9999) begin
            fails++;
            $display("FAIL load_reject: err=%b count=%h, want 1 9999", load_err, count_bcd);
        end
        tick1();
        tests++;
        if (load_err !== 1'b0) begin
            fails++;
            $display("FAIL load_err_pulse: err=%b, want 0", load_err);
        end
        run = 1'b1;
        repeat (3) tick1();
        load_bcd = 16'h0305; load_valid = 1'b1;
        tick1();
        load_valid = 1'b0;
        tests++;
        if (count_bcd !== 16'h0305 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL load_vs_step: count=%h wrap=%b, want 0305 0", count_bcd, wrap);
        end
        repeat (3) tick1();
        tests++;
        if (count_bcd !== 16'h0305) begin
            fails++;
            $display("FAIL tick_restart_hold: count=%h, want 0305", count_bcd);
        end
        tick1();
        tests++;
        if (count_bcd !== 16'h0306) begin
            fails++;
            $display("FAIL tick_restart_step: count=%h, want 0306", count_bcd);
        end
        run = 1'b0;
    endtask

    task automatic test_pause_scan();
        logic [3:0] prev;
        int changes, bad, frozen_bad, hold;
        bit first;
        changes = 0; bad = 0; frozen_bad = 0; hold = 0; first = 1'b1;
        tick1();
        prev = dig_en;
        repeat (100) begin
            tick1();
            hold++;
            if (count_bcd !== 16'h0306) frozen_bad++;
            if (dig_en !== prev) begin
                if (dig_en !== {prev[2:0], prev[3]}) bad++;
                if (!first && hold != 2) bad++;
                first = 1'b0;
                hold = 0;
                changes++;
                prev = dig_en;
            end
        end
        tests++;
        if (frozen_bad != 0) begin
            fails++;
            $display("FAIL pause_frozen: changed_samples=%0d, want 0", frozen_bad);
        end
        tests++;
        if (bad != 0 || changes < 49 || changes > 50) begin
            fails++;
            $display("FAIL pause_rotate: bad=%0d changes=%0d, want 0 49..50", bad, changes);
        end
    endtask

    task automatic test_reset_midrun();
        run = 1'b1;
        repeat (6) tick1();
        rst_n = 1'b0; load_valid = 1'b1; load_bcd = 16'h5555;
        tick1();
        tests++;
        if (count_bcd !== 16'h0000 || leds !== SB || dig_en !== 4'b0000 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: count=%h leds=%b dig_en=%b wrap=%b, want 0000 0000000 0000 0",
                     count_bcd, leds, dig_en, wrap);
        end
        rst_n = 1'b1; load_valid = 1'b0; run = 1'b0;
        tick1();
        tests++;
        if (dig_en !== 4'b0001 || leds !== S0 || count_bcd !== 16'h0000) begin
            fails++;
            $display("FAIL post_reset: dig_en=%b leds=%b count=%h, want 0001 0111111 0000",
                     dig_en, leds, count_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_pause_scan();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
